// File: rtl/ddr2_arbiter_pkg.sv
// ddr2_arbiter_pkg
//   Shared constants for the two-client DDR2 MIG arbiter:
//   - MIG command encodings (CMD_WRITE, CMD_READ)
//   - arbiter FSM state encodings
//   - clog2 helper for sizing counters and pointers
package ddr2_arbiter_pkg;

    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WDATA = 2'd1,
        ST_WCMD  = 2'd2,
        ST_RCMD  = 2'd3
    } arb_state_e;

    // Ceiling log2, never below 1 so that a 1-deep counter still has a bit.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/ddr2_tag_fifo.sv
// ddr2_tag_fifo
//   1-bit-wide synchronous FIFO recording which client issued each
//   outstanding read command.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   push_i, din_i   write a client id (ignored while full)
//   pop_i           drop the head entry (ignored while empty)
//   head_o          client id at the head
//   full_o, empty_o occupancy flags
module ddr2_tag_fifo
    import ddr2_arbiter_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic push_i,
    input  logic din_i,
    input  logic pop_i,
    output logic head_o,
    output logic full_o,
    output logic empty_o
);

    localparam int PW = clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0] mem_q;
    logic [PW-1:0]    wptr_q, rptr_q;
    logic [CW-1:0]    cnt_q;
    logic             push_ok, pop_ok;

    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q  <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wptr_q] <= din_i;
                wptr_q        <= wptr_q + PW'(1);
            end
            if (pop_ok) rptr_q <= rptr_q + PW'(1);
            // Simultaneous push and pop leaves occupancy unchanged.
            case ({push_ok, pop_ok})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign head_o  = mem_q[rptr_q];
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/ddr2_arbiter.sv
// ddr2_arbiter
//   Shares one DDR2 MIG user interface between clients c0 and c1 with
//   round-robin arbitration per burst. Write bursts pull BURST_WORDS words
//   from the selected client into the write-data FIFO, then issue the
//   command; read commands push the client id into a tag FIFO so returned
//   data is steered back to the issuer in return order.
// Ports:
//   s_clk, s_rst_n          clock, asynchronous active-low reset
//   s_phy_init_done         gates arbitration
//   cN_req/cmd_wr/addr      client burst request (held until grant)
//   cN_grant                one-cycle pulse when the command reaches MIG
//   cN_wdf_rd/data/mask     first-word-fall-through write data pull
//   cN_rd_data_valid/data   read return (data register shared)
//   s_app_af_*              MIG command FIFO
//   s_app_wdf_*             MIG write-data FIFO
//   s_app_rd_data*          MIG read return
//   s_rd_err                sticky: read data with no outstanding tag
module ddr2_arbiter
    import ddr2_arbiter_pkg::*;
#(
    parameter int APPDATA_WIDTH = 32,
    parameter int MASK_WIDTH    = 4,
    parameter int ADDR_WIDTH    = 31,
    parameter int BURST_WORDS   = 2,
    parameter int TAG_DEPTH     = 16
) (
    input  logic                     s_clk,
    input  logic                     s_rst_n,
    input  logic                     s_phy_init_done,
    input  logic                     c0_req,
    input  logic                     c0_cmd_wr,
    input  logic [ADDR_WIDTH-1:0]    c0_addr,
    output logic                     c0_grant,
    output logic                     c0_wdf_rd,
    input  logic [APPDATA_WIDTH-1:0] c0_wdf_data,
    input  logic [MASK_WIDTH-1:0]    c0_wdf_mask,
    output logic                     c0_rd_data_valid,
    output logic [APPDATA_WIDTH-1:0] c0_rd_data,
    input  logic                     c1_req,
    input  logic                     c1_cmd_wr,
    input  logic [ADDR_WIDTH-1:0]    c1_addr,
    output logic                     c1_grant,
    output logic                     c1_wdf_rd,
    input  logic [APPDATA_WIDTH-1:0] c1_wdf_data,
    input  logic [MASK_WIDTH-1:0]    c1_wdf_mask,
    output logic                     c1_rd_data_valid,
    output logic [APPDATA_WIDTH-1:0] c1_rd_data,
    output logic                     s_app_af_wren,
    output logic [2:0]               s_app_af_cmd,
    output logic [ADDR_WIDTH-1:0]    s_app_af_addr,
    input  logic                     s_app_af_afull,
    output logic                     s_app_wdf_wren,
    output logic [APPDATA_WIDTH-1:0] s_app_wdf_data,
    output logic [MASK_WIDTH-1:0]    s_app_wdf_mask_data,
    input  logic                     s_app_wdf_afull,
    input  logic                     s_app_rd_data_valid,
    input  logic [APPDATA_WIDTH-1:0] s_app_rd_data,
    output logic                     s_rd_err
);

    localparam int              BW        = clog2(BURST_WORDS);
    localparam logic [BW-1:0]   LAST_BEAT = BW'(BURST_WORDS - 1);

    arb_state_e               state_q;
    logic                     sel_q;     // client owning the current burst
    logic                     prio_q;    // client favoured on a tie
    logic [ADDR_WIDTH-1:0]    addr_q;
    logic [BW-1:0]            wcnt_q, beat_q;

    logic [1:0]               grant_q, rd_vld_q;
    logic                     af_wren_q, wdf_wren_q, rd_err_q;
    logic [2:0]               af_cmd_q;
    logic [ADDR_WIDTH-1:0]    af_addr_q;
    logic [APPDATA_WIDTH-1:0] wdf_data_q, rd_data_q;
    logic [MASK_WIDTH-1:0]    wdf_mask_q;

    logic                     any_req, win, win_wr, wdf_go, cmd_go;
    logic [ADDR_WIDTH-1:0]    win_addr;
    logic                     tag_push, tag_pop, tag_head, tag_full, tag_empty;

    assign any_req  = c0_req || c1_req;
    assign win      = (c0_req && c1_req) ? prio_q : c1_req;
    assign win_wr   = win ? c1_cmd_wr : c0_cmd_wr;
    assign win_addr = win ? c1_addr : c0_addr;

    assign wdf_go    = (state_q == ST_WDATA) && !s_app_wdf_afull;
    assign c0_wdf_rd = wdf_go && !sel_q;
    assign c1_wdf_rd = wdf_go && sel_q;

    // A read command may only issue when its tag has somewhere to go.
    assign cmd_go   = !s_app_af_afull &&
                      ((state_q == ST_WCMD) || ((state_q == ST_RCMD) && !tag_full));
    assign tag_push = (state_q == ST_RCMD) && cmd_go;
    assign tag_pop  = s_app_rd_data_valid && !tag_empty && (beat_q == LAST_BEAT);

    ddr2_tag_fifo #(.DEPTH(TAG_DEPTH)) u_tag_fifo (
        .clk_i   (s_clk),
        .rst_ni  (s_rst_n),
        .push_i  (tag_push),
        .din_i   (sel_q),
        .pop_i   (tag_pop),
        .head_o  (tag_head),
        .full_o  (tag_full),
        .empty_o (tag_empty)
    );

    always_ff @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state_q    <= ST_IDLE;
            sel_q      <= 1'b0;
            prio_q     <= 1'b0;
            addr_q     <= '0;
            wcnt_q     <= '0;
            grant_q    <= '0;
            af_wren_q  <= 1'b0;
            af_cmd_q   <= '0;
            af_addr_q  <= '0;
            wdf_wren_q <= 1'b0;
            wdf_data_q <= '0;
            wdf_mask_q <= '0;
        end else begin
            grant_q    <= '0;
            af_wren_q  <= 1'b0;
            wdf_wren_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (s_phy_init_done && any_req) begin
                        sel_q   <= win;
                        addr_q  <= win_addr;
                        state_q <= win_wr ? ST_WDATA : ST_RCMD;
                    end
                end
                ST_WDATA: begin
                    if (!s_app_wdf_afull) begin
                        wdf_wren_q <= 1'b1;
                        wdf_data_q <= sel_q ? c1_wdf_data : c0_wdf_data;
                        wdf_mask_q <= sel_q ? c1_wdf_mask : c0_wdf_mask;
                        if (wcnt_q == LAST_BEAT) begin
                            wcnt_q  <= '0;
                            state_q <= ST_WCMD;
                        end else begin
                            wcnt_q <= wcnt_q + BW'(1);
                        end
                    end
                end
                ST_WCMD, ST_RCMD: begin
                    if (cmd_go) begin
                        af_wren_q      <= 1'b1;
                        af_cmd_q       <= (state_q == ST_WCMD) ? CMD_WRITE : CMD_READ;
                        af_addr_q      <= addr_q;
                        grant_q[sel_q] <= 1'b1;
                        prio_q         <= ~sel_q;
                        state_q        <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Read return: the tag head picks the client; an empty tag FIFO means
    // the MIG returned data nobody asked for, so it is dropped and flagged.
    always_ff @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            rd_vld_q  <= '0;
            rd_data_q <= '0;
            rd_err_q  <= 1'b0;
            beat_q    <= '0;
        end else begin
            rd_vld_q <= '0;
            if (s_app_rd_data_valid) begin
                if (tag_empty) begin
                    rd_err_q <= 1'b1;
                end else begin
                    rd_vld_q[tag_head] <= 1'b1;
                    rd_data_q          <= s_app_rd_data;
                    beat_q             <= (beat_q == LAST_BEAT) ? '0 : beat_q + BW'(1);
                end
            end
        end
    end

    assign c0_grant            = grant_q[0];
    assign c1_grant            = grant_q[1];
    assign c0_rd_data_valid    = rd_vld_q[0];
    assign c1_rd_data_valid    = rd_vld_q[1];
    assign c0_rd_data          = rd_data_q;
    assign c1_rd_data          = rd_data_q;
    assign s_app_af_wren       = af_wren_q;
    assign s_app_af_cmd        = af_cmd_q;
    assign s_app_af_addr       = af_addr_q;
    assign s_app_wdf_wren      = wdf_wren_q;
    assign s_app_wdf_data      = wdf_data_q;
    assign s_app_wdf_mask_data = wdf_mask_q;
    assign s_rd_err            = rd_err_q;

endmodule

// File: tb/tb_ddr2_arbiter.sv
// tb_ddr2_arbiter
//   Directed bench for ddr2_arbiter: init gating, round-robin reads with
//   return steering, a write burst under write-FIFO backpressure, tag FIFO
//   full stall and release, spurious read data, and mid-burst reset.
module tb_ddr2_arbiter;

    localparam int DW = 32;
    localparam int MW = 4;
    localparam int AW = 31;

    logic          s_clk = 1'b0;
    logic          s_rst_n = 1'b0;
    logic          s_phy_init_done = 1'b0;
    logic          c0_req = 1'b0, c0_cmd_wr = 1'b0;
    logic [AW-1:0] c0_addr = '0;
    logic [DW-1:0] c0_wdf_data = '0;
    logic [MW-1:0] c0_wdf_mask = '0;
    logic          c1_req = 1'b0, c1_cmd_wr = 1'b0;
    logic [AW-1:0] c1_addr = '0;
    logic [DW-1:0] c1_wdf_data = 32'h1111_2222;
    logic [MW-1:0] c1_wdf_mask = 4'h5;
    logic          s_app_af_afull = 1'b0, s_app_wdf_afull = 1'b0;
    logic          s_app_rd_data_valid = 1'b0;
    logic [DW-1:0] s_app_rd_data = '0;

    logic          c0_grant, c0_wdf_rd, c0_rd_data_valid;
    logic          c1_grant, c1_wdf_rd, c1_rd_data_valid;
    logic [DW-1:0] c0_rd_data, c1_rd_data, s_app_wdf_data;
    logic          s_app_af_wren, s_app_wdf_wren, s_rd_err;
    logic [2:0]    s_app_af_cmd;
    logic [AW-1:0] s_app_af_addr;
    logic [MW-1:0] s_app_wdf_mask_data;

    int   n_tests = 0;
    int   n_fail  = 0;
    logic tag_q[$];

    ddr2_arbiter dut (
        .s_clk(s_clk), .s_rst_n(s_rst_n), .s_phy_init_done(s_phy_init_done),
        .c0_req(c0_req), .c0_cmd_wr(c0_cmd_wr), .c0_addr(c0_addr), .c0_grant(c0_grant),
        .c0_wdf_rd(c0_wdf_rd), .c0_wdf_data(c0_wdf_data), .c0_wdf_mask(c0_wdf_mask),
        .c0_rd_data_valid(c0_rd_data_valid), .c0_rd_data(c0_rd_data),
        .c1_req(c1_req), .c1_cmd_wr(c1_cmd_wr), .c1_addr(c1_addr), .c1_grant(c1_grant),
        .c1_wdf_rd(c1_wdf_rd), .c1_wdf_data(c1_wdf_data), .c1_wdf_mask(c1_wdf_mask),
        .c1_rd_data_valid(c1_rd_data_valid), .c1_rd_data(c1_rd_data),
        .s_app_af_wren(s_app_af_wren), .s_app_af_cmd(s_app_af_cmd),
        .s_app_af_addr(s_app_af_addr), .s_app_af_afull(s_app_af_afull),
        .s_app_wdf_wren(s_app_wdf_wren), .s_app_wdf_data(s_app_wdf_data),
        .s_app_wdf_mask_data(s_app_wdf_mask_data), .s_app_wdf_afull(s_app_wdf_afull),
        .s_app_rd_data_valid(s_app_rd_data_valid), .s_app_rd_data(s_app_rd_data),
        .s_rd_err(s_rd_err)
    );

    always #5 s_clk = ~s_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_grant(input int n, output bit got, output int cyc);
        got = 1'b0;
        cyc = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge s_clk);
            cyc = i + 1;
            if (c0_grant || c1_grant) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        c0_req = 1'b0;
        c1_req = 1'b0;
        s_app_rd_data_valid = 1'b0;
        s_rst_n = 1'b0;
        repeat (2) @(negedge s_clk);
        s_rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit            got, strobe;
        int            cyc, widx, n_wd, n_af, n_gr0, n_gr1, n_c1rd;
        logic          cl;
        logic [DW-1:0] wr_words [3];
        logic [MW-1:0] wr_masks [3];
        logic [DW-1:0] wd_seen  [2];
        logic [MW-1:0] wm_seen  [2];
        logic [2:0]    af_cmd_seen;
        logic [AW-1:0] af_addr_seen;
        bit            af_after_data;

        // ---- reset state, no arbitration before calibration ----
        c0_req = 1'b1; c0_cmd_wr = 1'b0; c0_addr = 31'h100;
        repeat (2) @(negedge s_clk);
        chk("rst_grant",    {c1_grant, c0_grant}, 2'b00);
        chk("rst_af_wren",  s_app_af_wren, 1'b0);
        chk("rst_af_cmd",   s_app_af_cmd, 3'b000);
        chk("rst_af_addr",  s_app_af_addr, 0);
        chk("rst_wdf_wren", s_app_wdf_wren, 1'b0);
        chk("rst_wdf_rd",   {c1_wdf_rd, c0_wdf_rd}, 2'b00);
        chk("rst_rd_vld",   {c1_rd_data_valid, c0_rd_data_valid}, 2'b00);
        chk("rst_rd_data",  c0_rd_data, 0);
        chk("rst_rd_err",   s_rd_err, 1'b0);
        s_rst_n = 1'b1;
        repeat (4) begin
            @(negedge s_clk);
            chk("noinit_grant", {c1_grant, c0_grant}, 2'b00);
            chk("noinit_af_wren", s_app_af_wren, 1'b0);
        end
        s_phy_init_done = 1'b1;
        wait_grant(3, got, cyc);
        chk("init_grant_seen", got, 1'b1);
        chk("init_grant_who",  {c1_grant, c0_grant}, 2'b01);
        chk("init_af_wren",    s_app_af_wren, 1'b1);
        chk("init_af_cmd",     s_app_af_cmd, 3'b001);
        chk("init_af_addr",    s_app_af_addr, 31'h100);
        c0_req = 1'b0;

        // ---- round-robin reads, then steered returns ----
        do_reset();
        c0_req = 1'b1; c0_addr = 31'h100;
        c1_req = 1'b1; c1_addr = 31'h200; c1_cmd_wr = 1'b0;
        for (int k = 0; k < 6; k++) begin
            wait_grant(4, got, cyc);
            chk("rr_seen", got, 1'b1);
            chk("rr_order", {c1_grant, c0_grant}, (k % 2) ? 2'b10 : 2'b01);
            chk("rr_addr", s_app_af_addr, (k % 2) ? 31'h200 : 31'h100);
            chk("rr_cmd", s_app_af_cmd, 3'b001);
            if (k > 0) chk("rr_spacing", cyc, 2);
            tag_q.push_back((k % 2) != 0);
        end
        c0_req = 1'b0; c1_req = 1'b0;
        for (int b = 0; b < 12; b++) begin
            s_app_rd_data_valid = 1'b1;
            s_app_rd_data = 32'hD000_0000 + b;
            @(negedge s_clk);
            cl = tag_q[b / 2];
            chk("ret_c0_vld", c0_rd_data_valid, cl == 1'b0);
            chk("ret_c1_vld", c1_rd_data_valid, cl == 1'b1);
            chk("ret_data",   c1_rd_data, 32'hD000_0000 + b);
        end
        s_app_rd_data_valid = 1'b0;
        @(negedge s_clk);
        chk("ret_idle",   {c1_rd_data_valid, c0_rd_data_valid}, 2'b00);
        chk("ret_no_err", s_rd_err, 1'b0);

        // ---- c0 write burst with write-FIFO afull toggling ----
        wr_words[0] = 32'hA5A5_0001; wr_masks[0] = 4'h0;
        wr_words[1] = 32'hA5A5_0002; wr_masks[1] = 4'h3;
        wr_words[2] = 32'hDEAD_BEEF; wr_masks[2] = 4'hF;
        widx = 0; strobe = 1'b0; n_wd = 0; n_af = 0; n_gr0 = 0; n_gr1 = 0; n_c1rd = 0;
        af_cmd_seen = 3'b111; af_addr_seen = '0; af_after_data = 1'b0;
        c0_wdf_data = wr_words[0]; c0_wdf_mask = wr_masks[0];
        c0_req = 1'b1; c0_cmd_wr = 1'b1; c0_addr = 31'h40;
        for (int c = 0; c < 14; c++) begin
            @(negedge s_clk);
            if (strobe && widx < 2) widx++;
            c0_wdf_data = wr_words[widx]; c0_wdf_mask = wr_masks[widx];
            if (s_app_wdf_wren) begin
                if (n_wd < 2) begin
                    wd_seen[n_wd] = s_app_wdf_data;
                    wm_seen[n_wd] = s_app_wdf_mask_data;
                end
                n_wd++;
            end
            if (s_app_af_wren) begin
                n_af++;
                af_cmd_seen = s_app_af_cmd;
                af_addr_seen = s_app_af_addr;
                af_after_data = (n_wd == 2);
            end
            if (c0_grant) begin n_gr0++; c0_req = 1'b0; end
            if (c1_grant) n_gr1++;
            s_app_wdf_afull = (c % 2) != 0;
            #1;
            strobe = c0_wdf_rd;
            if (c1_wdf_rd) n_c1rd++;
        end
        s_app_wdf_afull = 1'b0;
        chk("wr_wdf_count", n_wd, 2);
        chk("wr_word0", wd_seen[0], 32'hA5A5_0001);
        chk("wr_word1", wd_seen[1], 32'hA5A5_0002);
        chk("wr_mask0", wm_seen[0], 4'h0);
        chk("wr_mask1", wm_seen[1], 4'h3);
        chk("wr_af_count", n_af, 1);
        chk("wr_af_cmd", af_cmd_seen, 3'b000);
        chk("wr_af_addr", af_addr_seen, 31'h40);
        chk("wr_af_after_data", af_after_data, 1'b1);
        chk("wr_c0_grants", n_gr0, 1);
        chk("wr_c1_grants", n_gr1, 0);
        chk("wr_c1_no_strobe", n_c1rd, 0);

        // ---- fill the tag FIFO, 17th read stalls until a tag pops ----
        c0_cmd_wr = 1'b0; c0_addr = 31'h300; c0_req = 1'b1;
        for (int k = 0; k < 16; k++) begin
            wait_grant(4, got, cyc);
            chk("fill_grant", got && c0_grant, 1'b1);
        end
        repeat (6) begin
            @(negedge s_clk);
            chk("full_stall", {s_app_af_wren, c1_grant, c0_grant}, 3'b000);
        end
        s_app_rd_data_valid = 1'b1; s_app_rd_data = 32'hE000_0000;
        @(negedge s_clk);
        chk("rel_beat0_vld", {c1_rd_data_valid, c0_rd_data_valid}, 2'b01);
        chk("rel_beat0_no_grant", c0_grant, 1'b0);
        s_app_rd_data = 32'hE000_0001;
        @(negedge s_clk);
        chk("rel_beat1_vld", {c1_rd_data_valid, c0_rd_data_valid}, 2'b01);
        chk("rel_beat1_data", c0_rd_data, 32'hE000_0001);
        s_app_rd_data_valid = 1'b0;
        wait_grant(4, got, cyc);
        chk("rel_17th_grant", got && c0_grant, 1'b1);
        chk("rel_17th_cmd", s_app_af_cmd, 3'b001);
        c0_req = 1'b0;
        for (int b = 0; b < 32; b++) begin
            s_app_rd_data_valid = 1'b1;
            s_app_rd_data = 32'hF000_0000 + b;
            @(negedge s_clk);
            chk("drain_vld", {c1_rd_data_valid, c0_rd_data_valid}, 2'b01);
        end
        s_app_rd_data_valid = 1'b0;

        // ---- spurious read data with nothing outstanding ----
        @(negedge s_clk);
        s_app_rd_data_valid = 1'b1; s_app_rd_data = 32'h0000_0BAD;
        @(negedge s_clk);
        s_app_rd_data_valid = 1'b0;
        chk("spur_no_vld", {c1_rd_data_valid, c0_rd_data_valid}, 2'b00);
        chk("spur_err", s_rd_err, 1'b1);
        repeat (3) @(negedge s_clk);
        chk("spur_err_held", s_rd_err, 1'b1);

        // ---- reset in the middle of a c1 write burst ----
        c1_req = 1'b1; c1_cmd_wr = 1'b1; c1_addr = 31'h80;
        s_app_wdf_afull = 1'b1;
        repeat (3) @(negedge s_clk);
        s_app_wdf_afull = 1'b0;
        #1;
        chk("mid_wdata_strobe", {c1_wdf_rd, c0_wdf_rd}, 2'b10);
        s_rst_n = 1'b0;
        #1;
        chk("arst_wdf_rd",   {c1_wdf_rd, c0_wdf_rd}, 2'b00);
        chk("arst_rd_err",   s_rd_err, 1'b0);
        chk("arst_af_addr",  s_app_af_addr, 0);
        chk("arst_af_cmd",   s_app_af_cmd, 3'b000);
        chk("arst_wdf_data", s_app_wdf_data, 0);
        chk("arst_rd_data",  c0_rd_data, 0);
        chk("arst_pulses",   {s_app_af_wren, s_app_wdf_wren, c1_grant, c0_grant}, 4'b0000);
        c1_req = 1'b0;
        repeat (2) @(negedge s_clk);
        s_rst_n = 1'b1;
        repeat (3) begin
            @(negedge s_clk);
            chk("post_rst_idle", {s_app_wdf_wren, s_app_af_wren, c1_grant}, 3'b000);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
